// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - shared opcodes, response states and byte counts for the UART ALU
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  localparam int RES_BYTES = 4;
  localparam int DIV_BYTES = 8;

  typedef enum logic [1:0] {IDLE, RESULT, ECHO} tx_state_e;

  // Zero marks an opcode that has no result response.
  function automatic logic [3:0] result_bytes(input logic [7:0] op);
    case (op)
      OP_ADD, OP_MUL: return 4'(RES_BYTES);
      OP_DIV:         return 4'(DIV_BYTES);
      default:        return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_response_tx_if.sv
// rtl/alu_response_tx_if.sv - result, echo and tx byte handshakes of the response framer
interface alu_response_tx_if #(parameter int RESULT_W = 32);
  logic                res_valid_i;
  logic                res_ready_o;
  logic [7:0]          res_opcode_i;
  logic [RESULT_W-1:0] res_lo_i;
  logic [RESULT_W-1:0] res_hi_i;
  logic [7:0]          echo_data_i;
  logic                echo_valid_i;
  logic                echo_last_i;
  logic                echo_ready_o;
  logic [7:0]          tx_data_o;
  logic                tx_valid_o;
  logic                tx_ready_i;

  modport slave (
    input  res_valid_i, res_opcode_i, res_lo_i, res_hi_i,
    input  echo_data_i, echo_valid_i, echo_last_i, tx_ready_i,
    output res_ready_o, echo_ready_o, tx_data_o, tx_valid_o
  );

  modport master (
    output res_valid_i, res_opcode_i, res_lo_i, res_hi_i,
    output echo_data_i, echo_valid_i, echo_last_i, tx_ready_i,
    input  res_ready_o, echo_ready_o, tx_data_o, tx_valid_o
  );
endinterface

// File: rtl/alu_response_tx_result_serializer.sv
// rtl/alu_response_tx_result_serializer.sv - little-endian byte shifter for latched ALU results
module result_serializer #(
  parameter int RESULT_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load,
  input  logic [2*RESULT_W-1:0] load_data,
  input  logic [3:0]            load_count,
  input  logic                  shift,
  output logic [7:0]            byte_data,
  output logic                  done
);

  logic [2*RESULT_W-1:0] sreg;
  logic [3:0]            count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg  <= '0;
      count <= '0;
    end else if (load) begin
      sreg  <= load_data;
      count <= load_count;
    end else if (shift && count != 4'd0) begin
      sreg  <= sreg >> 8;
      count <= count - 4'd1;
    end
  end

  assign byte_data = sreg[7:0];
  assign done      = (count == 4'd1);

endmodule

// File: rtl/alu_response_tx.sv
// rtl/alu_response_tx.sv - frames ALU results and echo bytes into the UART TX byte stream
module alu_response_tx
  import uart_alu_pkg::*;
#(
  parameter int RESULT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_response_tx_if.slave   bus,
  output logic               busy_o,
  output logic               err_o
);

  tx_state_e  state, state_nxt;
  logic [3:0] res_count;
  logic       res_known;
  logic       ser_load, ser_shift, ser_done;
  logic [7:0] ser_byte;
  logic [7:0] echo_data_q;
  logic       echo_valid_q, echo_last_q;
  logic       echo_take;

  assign res_count = result_bytes(bus.res_opcode_i);
  assign res_known = (res_count != 4'd0);

  result_serializer #(.RESULT_W(RESULT_W)) u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (ser_load),
    .load_data  ({bus.res_hi_i, bus.res_lo_i}),
    .load_count (res_count),
    .shift      (ser_shift),
    .byte_data  (ser_byte),
    .done       (ser_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.res_valid_i) begin
          if (res_known) state_nxt = RESULT;
        end else if (bus.echo_valid_i) begin
          state_nxt = ECHO;
        end
      end
      RESULT: if (bus.tx_ready_i && ser_done) state_nxt = IDLE;
      ECHO:   if (echo_valid_q && echo_last_q && bus.tx_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Once the last echo byte sits in the output register, no further echo byte is taken.
  always_comb begin
    bus.res_ready_o  = (state == IDLE);
    bus.echo_ready_o = (state == ECHO) && (!echo_valid_q || (bus.tx_ready_i && !echo_last_q));
    ser_load         = (state == IDLE) && bus.res_valid_i && res_known;
    ser_shift        = (state == RESULT) && bus.tx_ready_i;
    err_o            = (state == IDLE) && bus.res_valid_i && !res_known;
    busy_o           = (state != IDLE);
    bus.tx_valid_o   = (state == RESULT) ? 1'b1 : echo_valid_q;
    bus.tx_data_o    = (state == RESULT) ? ser_byte : echo_data_q;
    echo_take        = bus.echo_ready_o && bus.echo_valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      echo_data_q  <= 8'h00;
      echo_valid_q <= 1'b0;
      echo_last_q  <= 1'b0;
    end else if (echo_take) begin
      echo_data_q  <= bus.echo_data_i;
      echo_valid_q <= 1'b1;
      echo_last_q  <= bus.echo_last_i;
    end else if (bus.tx_ready_i) begin
      echo_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_response_tx.sv
// tb/tb_alu_response_tx.sv - directed checks of result framing, echo pass-through and reset
module tb_alu_response_tx;
  import uart_alu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic busy_o, err_o;

  alu_response_tx_if #(.RESULT_W(32)) bus ();

  alu_response_tx #(.RESULT_W(32)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus.slave),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] got_q[$];
  int first_cyc, last_cyc;
  int echo_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [63:0] exp);
    for (int i = 0; i < n; i++)
      if (i < got_q.size())
        check($sformatf("%s byte %0d", tag, i), {56'd0, got_q[i]}, {56'd0, exp[8*i +: 8]});
  endtask

  // Called at a falling edge; returns at the falling edge after the n-th handshake.
  task automatic collect(input int mode, input int n, input int max_cyc);
    logic       r;
    logic       stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = 8'h00;
    got_q.delete();
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < max_cyc && got_q.size() < n; c++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 4 == 0) || (c % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.tx_ready_i = r;
      #1;
      if (stall) begin
        check("stall valid held", {63'd0, bus.tx_valid_o}, 64'd1);
        check("stall data held", {56'd0, bus.tx_data_o}, {56'd0, held});
      end
      stall = bus.tx_valid_o && !bus.tx_ready_i;
      held  = bus.tx_data_o;
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got_q.push_back(bus.tx_data_o);
      end
      @(negedge clk_i);
    end
    bus.tx_ready_i = 1'b0;
    check("byte count", 64'(got_q.size()), 64'(n));
  endtask

  task automatic offer_result(input logic [7:0] op, input logic [31:0] lo, input logic [31:0] hi);
    bus.res_valid_i  = 1'b1;
    bus.res_opcode_i = op;
    bus.res_lo_i     = lo;
    bus.res_hi_i     = hi;
    #1;
    check("res_ready on offer", {63'd0, bus.res_ready_o}, 64'd1);
    @(negedge clk_i);
    bus.res_valid_i = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_echo [20];
    int extra;
    bus.res_valid_i  = 1'b0;
    bus.res_opcode_i = 8'h00;
    bus.res_lo_i     = '0;
    bus.res_hi_i     = '0;
    bus.echo_data_i  = 8'h00;
    bus.echo_valid_i = 1'b0;
    bus.echo_last_i  = 1'b0;
    bus.tx_ready_i   = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check("reset tx_valid", {63'd0, bus.tx_valid_o}, 64'd0);
    check("reset tx_data", {56'd0, bus.tx_data_o}, 64'd0);
    check("reset busy", {63'd0, busy_o}, 64'd0);
    check("reset err", {63'd0, err_o}, 64'd0);
    check("reset res_ready", {63'd0, bus.res_ready_o}, 64'd1);
    check("reset echo_ready", {63'd0, bus.echo_ready_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    offer_result(OP_ADD, 32'h12345678, 32'hFFFFFFFF);
    collect(0, 4, 20);
    check_bytes("add", 4, 64'h0000_0000_1234_5678);
    check("add first cycle", 64'(first_cyc), 64'd0);
    check("add last cycle", 64'(last_cyc), 64'd3);
    #1;
    check("add res_ready after", {63'd0, bus.res_ready_o}, 64'd1);
    check("add busy after", {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);

    offer_result(OP_DIV, 32'h00000003, 32'h00000021);
    collect(0, 8, 30);
    check_bytes("div", 8, 64'h0000_0021_0000_0003);
    check("div last cycle", 64'(last_cyc), 64'd7);

    offer_result(OP_MUL, 32'hDEADBEEF, 32'h0);
    collect(1, 4, 40);
    check_bytes("mul", 4, 64'h0000_0000_DEAD_BEEF);

    bus.res_opcode_i = 8'h55;
    bus.res_valid_i  = 1'b1;
    #1;
    check("bad op err pulse", {63'd0, err_o}, 64'd1);
    check("bad op accepted", {63'd0, bus.res_ready_o}, 64'd1);
    @(negedge clk_i);
    bus.res_valid_i = 1'b0;
    #1;
    check("bad op err cleared", {63'd0, err_o}, 64'd0);
    check("bad op no tx", {63'd0, bus.tx_valid_o}, 64'd0);
    check("bad op idle", {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);

    for (int i = 0; i < 16; i++) exp_echo[i] = 8'(i + 1);
    exp_echo[16] = 8'h0D; exp_echo[17] = 8'h0C; exp_echo[18] = 8'h0B; exp_echo[19] = 8'h0A;
    echo_idx = 0;
    fork
      begin
        for (int c = 0; c < 400 && echo_idx < 16; c++) begin
          bus.echo_valid_i = 1'b1;
          bus.echo_data_i  = 8'(echo_idx + 1);
          bus.echo_last_i  = (echo_idx == 15);
          #1;
          if (bus.echo_ready_o) echo_idx++;
          @(negedge clk_i);
        end
        bus.echo_valid_i = 1'b0;
        bus.echo_last_i  = 1'b0;
      end
      begin
        for (int w = 0; w < 400 && echo_idx < 8; w++) @(negedge clk_i);
        bus.res_valid_i  = 1'b1;
        bus.res_opcode_i = OP_ADD;
        bus.res_lo_i     = 32'h0A0B0C0D;
        #1;
        check("res held off in echo", {63'd0, bus.res_ready_o}, 64'd0);
        for (int c = 0; c < 400 && !bus.res_ready_o; c++) begin
          @(negedge clk_i);
          #1;
        end
        @(negedge clk_i);
        bus.res_valid_i = 1'b0;
      end
      collect(2, 20, 800);
    join
    for (int i = 0; i < 20; i++)
      if (i < got_q.size())
        check($sformatf("echo seq byte %0d", i), {56'd0, got_q[i]}, {56'd0, exp_echo[i]});
    #1;
    check("echo then idle", {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);

    offer_result(OP_DIV, 32'h11223344, 32'h55667788);
    collect(0, 2, 20);
    check_bytes("div pre-reset", 2, 64'h0000_0000_0000_3344);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("mid reset tx_valid", {63'd0, bus.tx_valid_o}, 64'd0);
    check("mid reset busy", {63'd0, busy_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    offer_result(OP_ADD, 32'h00000004, 32'h0);
    collect(0, 4, 20);
    check_bytes("add after reset", 4, 64'h0000_0000_0000_0004);
    extra = 0;
    bus.tx_ready_i = 1'b1;
    repeat (4) begin
      #1;
      if (bus.tx_valid_o) extra++;
      @(negedge clk_i);
    end
    check("no stray bytes", 64'(extra), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
